// File: rtl/call_frame_ctrl.sv
// Call/return frame controller: saves {return pc, frame base} on call, restores them on return,
// and halts with a sticky trap code on overflow, bad argument count or a top-level return.
module call_frame_ctrl #(
  parameter int ROM_ADDR    = 6,
  parameter int STACK_DEPTH = 7,
  parameter int CALL_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_req,
  input  logic [ROM_ADDR-1:0]   call_target,
  input  logic [ROM_ADDR-1:0]   call_ret_pc,
  input  logic [STACK_DEPTH:0]  call_nargs,
  input  logic                  ret_req,
  input  logic [STACK_DEPTH:0]  sp,
  output logic                  busy,
  output logic                  done,
  output logic                  pc_load,
  output logic [ROM_ADDR-1:0]   pc_next,
  output logic [STACK_DEPTH:0]  fp,
  output logic [STACK_DEPTH:0]  ret_sp,
  output logic [CALL_DEPTH:0]   depth,
  output logic [3:0]            trap
);

  localparam int FW = ROM_ADDR + STACK_DEPTH + 1;
  localparam logic [CALL_DEPTH:0] MAX_DEPTH = (CALL_DEPTH+1)'(1) << CALL_DEPTH;

  typedef enum logic [2:0] {IDLE, CALL_SAVE, CALL_JUMP, RET_LOAD, RET_JUMP, HALT} state_t;

  state_t                state, state_nx;
  logic [ROM_ADDR-1:0]   target_q, target_nx, ret_pc_q, ret_pc_nx, pc_next_nx;
  logic [STACK_DEPTH:0]  new_fp_q, new_fp_nx, fp_nx, ret_sp_nx;
  logic [CALL_DEPTH:0]   depth_nx;
  logic [3:0]            trap_nx;
  logic                  done_nx, pc_load_nx;
  logic [FW-1:0]         frames [2**CALL_DEPTH];
  logic [FW-1:0]         frame_rd;
  logic [CALL_DEPTH-1:0] rd_idx;

  assign rd_idx = depth[CALL_DEPTH-1:0] - (CALL_DEPTH)'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pc_load  <= 1'b0;
      pc_next  <= '0;
      fp       <= '0;
      ret_sp   <= '0;
      depth    <= '0;
      trap     <= '0;
      target_q <= '0;
      ret_pc_q <= '0;
      new_fp_q <= '0;
    end else begin
      state    <= state_nx;
      busy     <= (state_nx != IDLE);
      done     <= done_nx;
      pc_load  <= pc_load_nx;
      pc_next  <= pc_next_nx;
      fp       <= fp_nx;
      ret_sp   <= ret_sp_nx;
      depth    <= depth_nx;
      trap     <= trap_nx;
      target_q <= target_nx;
      ret_pc_q <= ret_pc_nx;
      new_fp_q <= new_fp_nx;
    end
  end

  // Frame storage is only meaningful below depth, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == CALL_SAVE) frames[depth[CALL_DEPTH-1:0]] <= {ret_pc_q, fp};
    if (state == RET_LOAD) frame_rd <= frames[rd_idx];
  end

  always_comb begin
    state_nx   = state;
    target_nx  = target_q;
    ret_pc_nx  = ret_pc_q;
    new_fp_nx  = new_fp_q;
    pc_next_nx = pc_next;
    fp_nx      = fp;
    ret_sp_nx  = ret_sp;
    depth_nx   = depth;
    trap_nx    = trap;
    done_nx    = 1'b0;
    pc_load_nx = 1'b0;
    case (state)
      IDLE: begin
        // The done cycle blocks acceptance so a request not yet dropped is not re-taken.
        if (!done && trap == 4'd0) begin
          if (call_req) begin
            if (depth == MAX_DEPTH) begin
              state_nx = HALT;
              trap_nx  = 4'd2;
            end else if (call_nargs > sp) begin
              state_nx = HALT;
              trap_nx  = 4'd3;
            end else begin
              target_nx = call_target;
              ret_pc_nx = call_ret_pc;
              new_fp_nx = sp - call_nargs;
              state_nx  = CALL_SAVE;
            end
          end else if (ret_req) begin
            if (depth == '0) begin
              state_nx = HALT;
              trap_nx  = 4'd1;
            end else begin
              state_nx = RET_LOAD;
            end
          end
        end
      end
      CALL_SAVE: begin
        depth_nx = depth + (CALL_DEPTH+1)'(1);
        state_nx = CALL_JUMP;
      end
      CALL_JUMP: begin
        fp_nx      = new_fp_q;
        pc_next_nx = target_q;
        pc_load_nx = 1'b1;
        done_nx    = 1'b1;
        state_nx   = IDLE;
      end
      RET_LOAD: begin
        depth_nx = depth - (CALL_DEPTH+1)'(1);
        state_nx = RET_JUMP;
      end
      RET_JUMP: begin
        ret_sp_nx  = fp;
        fp_nx      = frame_rd[STACK_DEPTH:0];
        pc_next_nx = frame_rd[FW-1:STACK_DEPTH+1];
        pc_load_nx = 1'b1;
        done_nx    = 1'b1;
        state_nx   = IDLE;
      end
      HALT: state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_call_frame_ctrl.sv
// Self-checking bench for call_frame_ctrl: directed vector table, hand-written corner
// sequences, and randomized requests scored against a queue-based frame-stack model.
module tb_call_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       call_req = 1'b0, ret_req = 1'b0;
  logic [5:0] call_target = '0, call_ret_pc = '0;
  logic [7:0] call_nargs = '0, sp = '0;
  logic       busy, done, pc_load;
  logic [5:0] pc_next;
  logic [7:0] fp, ret_sp;
  logic [4:0] depth;
  logic [3:0] trap;

  call_frame_ctrl dut (
    .clk(clk), .reset(reset), .call_req(call_req), .call_target(call_target),
    .call_ret_pc(call_ret_pc), .call_nargs(call_nargs), .ret_req(ret_req), .sp(sp),
    .busy(busy), .done(done), .pc_load(pc_load), .pc_next(pc_next), .fp(fp),
    .ret_sp(ret_sp), .depth(depth), .trap(trap)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  int obs_lat, obs_done_cnt, obs_pl_cnt, obs_pc, obs_fp, obs_ret_sp, obs_depth, obs_trap, obs_busy_end;

  typedef struct { int pc; int fp; } frame_t;
  frame_t m_stack[$];
  int m_fp, m_trap;
  int e_kind, e_pc, e_fp, e_ret_sp, e_trap;

  typedef struct {
    bit pre_reset; bit c; bit r;
    int tgt; int rpc; int na; int spv;
    int exp_trap; int exp_pc; int exp_fp; int exp_depth; int exp_ret_sp;
  } vec_t;
  vec_t vecs[$];

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; call_req = 1'b0; ret_req = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_state", int'({busy, done, pc_load, pc_next, fp, ret_sp, depth, trap}), 0);
    reset = 1'b1;
    m_stack.delete(); m_fp = 0; m_trap = 0;
  endtask

  // Requests are dropped in the done cycle; after a trap they stay high to show they are ignored.
  task automatic apply_stimulus(input bit c, input bit r, input int tgt, input int rpc,
                                input int na, input int spv);
    @(negedge clk);
    call_req = c; ret_req = r;
    call_target = 6'(tgt); call_ret_pc = 6'(rpc); call_nargs = 8'(na); sp = 8'(spv);
    obs_lat = 0; obs_done_cnt = 0; obs_pl_cnt = 0;
    obs_pc = -1; obs_fp = -1; obs_ret_sp = -1; obs_depth = -1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (obs_lat == 0 && (done || trap != 4'd0)) obs_lat = i;
      if (pc_load) obs_pl_cnt++;
      if (done) begin
        obs_done_cnt++;
        obs_pc = int'(pc_next); obs_fp = int'(fp); obs_ret_sp = int'(ret_sp); obs_depth = int'(depth);
        call_req = 1'b0; ret_req = 1'b0;
      end
    end
    obs_trap = int'(trap); obs_busy_end = int'(busy);
    if (obs_depth < 0) obs_depth = int'(depth);
    call_req = 1'b0; ret_req = 1'b0;
  endtask

  function automatic void model_step(input bit c, input bit r, input int tgt, input int rpc,
                                     input int na, input int spv);
    frame_t f;
    e_kind = 2; e_pc = -1; e_fp = m_fp; e_ret_sp = -1; e_trap = m_trap;
    if (m_trap != 0) return;
    if (c) begin
      if (m_stack.size() == 16) begin e_kind = 1; m_trap = 2; end
      else if (na > spv) begin e_kind = 1; m_trap = 3; end
      else begin
        f.pc = rpc; f.fp = m_fp;
        m_stack.push_back(f);
        m_fp = spv - na; e_pc = tgt; e_kind = 0;
      end
    end else if (r) begin
      if (m_stack.size() == 0) begin e_kind = 1; m_trap = 1; end
      else begin
        f = m_stack.pop_back();
        e_ret_sp = m_fp; m_fp = f.fp; e_pc = f.pc; e_kind = 0;
      end
    end
    e_fp = m_fp; e_trap = m_trap;
  endfunction

  task automatic check_against(input string tag, input int kind, input bit is_ret, input int ex_pc,
                               input int ex_fp, input int ex_depth, input int ex_ret_sp, input int ex_trap);
    if (kind == 0) begin
      check_output({tag, "_latency"}, obs_lat, 3);
      check_output({tag, "_done_pulses"}, obs_done_cnt, 1);
      check_output({tag, "_pc_load_pulses"}, obs_pl_cnt, 1);
      check_output({tag, "_pc_next"}, obs_pc, ex_pc);
      check_output({tag, "_fp"}, obs_fp, ex_fp);
      check_output({tag, "_depth"}, obs_depth, ex_depth);
      check_output({tag, "_busy_after"}, obs_busy_end, 0);
      if (is_ret) check_output({tag, "_ret_sp"}, obs_ret_sp, ex_ret_sp);
    end else begin
      if (kind == 1) check_output({tag, "_trap_latency"}, obs_lat, 1);
      check_output({tag, "_trap"}, obs_trap, ex_trap);
      check_output({tag, "_no_pc_load"}, obs_pl_cnt, 0);
      check_output({tag, "_no_done"}, obs_done_cnt, 0);
      check_output({tag, "_busy_halt"}, obs_busy_end, 1);
    end
  endtask

  task automatic run_model_req(input string tag, input bit c, input bit r, input int tgt,
                               input int rpc, input int na, input int spv);
    model_step(c, r, tgt, rpc, na, spv);
    apply_stimulus(c, r, tgt, rpc, na, spv);
    check_against(tag, e_kind, r && !c, e_pc, e_fp, m_stack.size(), e_ret_sp, e_trap);
  endtask

  initial begin
    vec_t v;
    int sp_r, na_r, x;
    bit c_r, r_r;

    vecs.push_back('{1, 1, 0, 33, 10, 2, 5, 0, 33, 3, 1, -1});
    vecs.push_back('{0, 0, 1,  0,  0, 0, 0, 0, 10, 0, 0,  3});
    vecs.push_back('{0, 1, 1, 20,  7, 0, 4, 0, 20, 4, 1, -1});
    vecs.push_back('{0, 1, 0, 40, 21, 3, 9, 0, 40, 6, 2, -1});
    vecs.push_back('{0, 0, 1,  0,  0, 0, 0, 0, 21, 4, 1,  6});
    vecs.push_back('{0, 0, 1,  0,  0, 0, 0, 0,  7, 0, 0,  4});
    vecs.push_back('{1, 1, 0, 12,  3, 4, 2, 3,  0, 0, 0, -1});
    vecs.push_back('{1, 0, 1,  0,  0, 0, 0, 1,  0, 0, 0, -1});
    vecs.push_back('{1, 1, 0, 63, 62, 255, 255, 0, 63, 0, 1, -1});

    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_stack.delete(); m_fp = 0; m_trap = 0;

    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.pre_reset) do_reset();
      apply_stimulus(v.c, v.r, v.tgt, v.rpc, v.na, v.spv);
      check_against($sformatf("vec%0d", i), (v.exp_trap == 0) ? 0 : 1, v.r && !v.c,
                    v.exp_pc, v.exp_fp, v.exp_depth, v.exp_ret_sp, v.exp_trap);
    end

    // Asynchronous reset landing while a call is in CALL_SAVE.
    do_reset();
    run_model_req("pre_reset_call", 1, 0, 33, 10, 2, 5);
    @(negedge clk);
    call_req = 1'b1; call_target = 6'd9; call_ret_pc = 6'd4; call_nargs = 8'd1; sp = 8'd6;
    @(posedge clk); #1;
    check_output("in_call_save_busy", int'(busy), 1);
    #2 reset = 1'b0;
    #1 check_output("async_reset_outputs", int'({busy, done, pc_load, pc_next, fp, ret_sp, depth, trap}), 0);
    call_req = 1'b0;
    @(posedge clk); #1;
    check_output("held_reset_depth", int'(depth), 0);
    @(negedge clk) reset = 1'b1;
    m_stack.delete(); m_fp = 0; m_trap = 0;
    run_model_req("post_reset_call", 1, 0, 17, 2, 0, 3);

    // Sixteen nested calls fill the frame memory; the seventeenth overflows.
    do_reset();
    for (int i = 0; i < 16; i++)
      run_model_req($sformatf("nest%0d", i), 1, 0, i + 1, 40 + i, 1, 20 + i);
    check_output("full_depth", int'(depth), 16);
    run_model_req("overflow", 1, 0, 5, 5, 0, 5);
    run_model_req("after_overflow_ret", 0, 1, 0, 0, 0, 0);
    run_model_req("after_overflow_call", 1, 0, 2, 2, 0, 9);

    // Randomized traffic against the frame-stack model.
    do_reset();
    for (int n = 0; n < 250; n++) begin
      x = $urandom_range(0, 99);
      c_r = (x < 55) || (x >= 95);
      r_r = (x >= 55);
      sp_r = $urandom_range(0, 255);
      na_r = ($urandom_range(0, 39) == 0 && sp_r < 255) ? sp_r + 1 : $urandom_range(0, sp_r);
      run_model_req($sformatf("rnd%0d", n), c_r, r_r, $urandom_range(0, 63),
                    $urandom_range(0, 63), na_r, sp_r);
      if (m_trap != 0) begin
        run_model_req($sformatf("rnd%0d_halted", n), 1, 1, 1, 1, 0, 1);
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/call_frame_ctrl.md
CALL_FRAME_CTRL -- requirements
Module: call_frame_ctrl

Interface
REQ-001 The block SHALL have parameter ROM_ADDR, default 6, meaning the program counter width.
REQ-002 The block SHALL have parameter STACK_DEPTH, default 7, meaning operand-stack index width minus 1 (indices are STACK_DEPTH+1 bits).
REQ-003 The block SHALL have parameter CALL_DEPTH, default 4, meaning frame memory holds 2**CALL_DEPTH frames.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port call_req, input, 1 bit: call request, level.
REQ-007 The block SHALL have port call_target, input, ROM_ADDR bits: callee entry pc.
REQ-008 The block SHALL have port call_ret_pc, input, ROM_ADDR bits: pc to resume at after return.
REQ-009 The block SHALL have port call_nargs, input, STACK_DEPTH+1 bits: number of arguments already on the operand stack.
REQ-010 The block SHALL have port ret_req, input, 1 bit: return request, level.
REQ-011 The block SHALL have port sp, input, STACK_DEPTH+1 bits: current operand-stack pointer.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port pc_load, output, 1 bit: one-cycle strobe to load pc_next into the program counter.
REQ-015 The block SHALL have port pc_next, output, ROM_ADDR bits: the pc value to load.
REQ-016 The block SHALL have port fp, output, STACK_DEPTH+1 bits: current frame base.
REQ-017 The block SHALL have port ret_sp, output, STACK_DEPTH+1 bits: operand-stack truncate point, valid when done follows a return.
REQ-018 The block SHALL have port depth, output, CALL_DEPTH+1 bits: count of live frames.
REQ-019 The block SHALL have port trap, output, 4 bits: 0 none, 1 ended (return at top level), 2 call overflow, 3 bad argument count.

Function
REQ-020 The FSM SHALL have states IDLE, CALL_SAVE, CALL_JUMP, RET_LOAD, RET_JUMP and HALT, and all outputs SHALL be registered.
REQ-021 A request SHALL be accepted only on a rising edge where the state is IDLE, done=0 and trap=0; requests at any other time SHALL be ignored and not queued.
REQ-022 If call_req and ret_req are both high at acceptance, the call SHALL win and the return SHALL be dropped.
REQ-023 On call acceptance, the block SHALL go to HALT with trap=2 if depth==2**CALL_DEPTH, else to HALT with trap=3 if call_nargs>sp, else latch the inputs and go to CALL_SAVE.
REQ-024 In CALL_SAVE, the block SHALL write {call_ret_pc, fp} into frame[depth], increment depth, and go to CALL_JUMP.
REQ-025 In CALL_JUMP, the block SHALL set fp=sp-call_nargs (latched values), set pc_next=call_target, assert pc_load and done for one cycle, and return to IDLE.
REQ-026 Call latency SHALL be: accepted at edge N, pc_load/done high in the cycle after edge N+2.
REQ-027 On return acceptance, the block SHALL go to HALT with trap=1 if depth==0, else to RET_LOAD.
REQ-028 In RET_LOAD, the block SHALL decrement depth, read frame[depth-1], and go to RET_JUMP.
REQ-029 In RET_JUMP, the block SHALL set ret_sp to the old fp, restore fp and pc_next from the frame, assert pc_load and done for one cycle, and return to IDLE; return latency SHALL equal call latency.
REQ-030 The sp-call_nargs subtraction SHALL be computed at STACK_DEPTH+1 bits and SHALL never underflow, because REQ-023 guards it; depth SHALL never wrap.
REQ-031 HALT SHALL be terminal: trap is sticky, busy=1, no pc_load, and only reset exits it.
REQ-032 The requester SHALL hold its request until done and drop it in the done cycle; a request still high during done SHALL NOT be accepted.

Reset
REQ-033 While reset=0, state SHALL be IDLE and busy, done, pc_load, pc_next, fp, ret_sp, depth and trap SHALL all be 0; this applies asynchronously, including mid-operation.
REQ-034 Frame memory contents SHALL NOT need reset; frames are invalid whenever depth is 0.

Verification
REQ-035 Reset: assert reset=0 during CALL_SAVE -> all outputs 0 immediately, state IDLE, depth=0.
REQ-036 Call: sp=5, call_nargs=2, call_target=33, call_ret_pc=10 -> two edges after acceptance pc_load=1, pc_next=33, fp=3, depth=1, done high exactly 1 cycle.
REQ-037 Return: return after the REQ-036 call -> pc_next=10, fp=0, ret_sp=3, depth=0, pc_load and done pulse once.
REQ-038 Overflow: 16 nested calls succeed (depth=16), then a 17th call -> trap=2, busy=1, and later requests produce no pc_load.
REQ-039 Top return: ret_req at depth 0 -> trap=1 on the next edge, pc_load never asserted.
REQ-040 Bad arguments and simultaneous requests: call_nargs=4 with sp=2 -> trap=3; call_req and ret_req together with depth=0 -> call executes, depth=1, trap=0.
